// File: rtl/demux1to4_buf.sv
// demux1to4_buf: registered 1-to-4 steering demux.
// One producer stream is routed by Sel into four independent one-deep output
// slots. Each slot has its own valid/ready handshake, so a stalled consumer
// only blocks words addressed to its own channel.

// One output slot: a data register plus a full flag, loaded on accept and
// emptied on drain. A load in the same cycle as a drain keeps the slot full.
module demux1to4_buf_slot #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             valid_nxt
);

  // Next full state, shared with the top for the occupancy count.
  assign valid_nxt = load | (valid & ~ready);

  // Data only moves on a load; valid follows valid_nxt.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data  <= '0;
      valid <= 1'b0;
    end else begin
      if (load) data <= din;
      valid <= valid_nxt;
    end
  end

endmodule

module demux1to4_buf #(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] In,
  input  logic [1:0]       Sel,
  input  logic             In_valid,
  output logic             In_ready,
  output logic [WIDTH-1:0] Out1,
  output logic [WIDTH-1:0] Out2,
  output logic [WIDTH-1:0] Out3,
  output logic [WIDTH-1:0] Out4,
  output logic [3:0]       Out_valid,
  input  logic [3:0]       Out_ready,
  output logic [2:0]       Occupancy
);

  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][WIDTH-1:0] dout;
  logic [NUM_LANES-1:0]            load;
  logic [NUM_LANES-1:0]            vnxt;
  logic                            accept;
  logic [2:0]                      occ_nxt;

  // Only the selected slot can back-pressure the producer.
  assign In_ready = RST_N & (~Out_valid[Sel] | Out_ready[Sel]);
  assign accept   = In_valid & In_ready;

  // One-hot load strobe from the select.
  always_comb begin
    load = '0;
    load[Sel] = accept;
  end

  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_slot
      demux1to4_buf_slot #(.WIDTH(WIDTH)) u_slot (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .load      (load[g]),
        .din       (In),
        .ready     (Out_ready[g]),
        .data      (dout[g]),
        .valid     (Out_valid[g]),
        .valid_nxt (vnxt[g])
      );
    end
  endgenerate

  assign Out1 = dout[0];
  assign Out2 = dout[1];
  assign Out3 = dout[2];
  assign Out4 = dout[3];

  // Popcount of the next-state valid bits, so Occupancy tracks Out_valid
  // at the same edge.
  always_comb begin
    occ_nxt = '0;
    for (int i = 0; i < NUM_LANES; i++) occ_nxt = occ_nxt + {2'b00, vnxt[i]};
  end

  // Registered occupancy.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) Occupancy <= '0;
    else        Occupancy <= occ_nxt;
  end

endmodule

// File: tb/tb_demux1to4_buf.sv
// Bench for demux1to4_buf: directed vector table, hand sequences for async
// reset and back-pressure, randomized run against a per-channel slot model,
// and an in-order streaming scoreboard.
module tb_demux1to4_buf;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] In;
  logic [1:0]  Sel;
  logic        In_valid;
  logic        In_ready;
  logic [31:0] Out1, Out2, Out3, Out4;
  logic [3:0]  Out_valid;
  logic [3:0]  Out_ready;
  logic [2:0]  Occupancy;
  logic [3:0][31:0] outs;

  int errors = 0;
  int checks = 0;

  demux1to4_buf #(.WIDTH(32)) dut (
    .CLK(CLK), .RST_N(RST_N), .In(In), .Sel(Sel), .In_valid(In_valid),
    .In_ready(In_ready), .Out1(Out1), .Out2(Out2), .Out3(Out3), .Out4(Out4),
    .Out_valid(Out_valid), .Out_ready(Out_ready), .Occupancy(Occupancy)
  );

  always #5 CLK = ~CLK;
  assign outs = {Out4, Out3, Out2, Out1};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [1:0] s, input logic v, input logic [3:0] r);
    In = d; Sel = s; In_valid = v; Out_ready = r;
  endtask

  typedef struct {
    logic [31:0]      din;
    logic [1:0]       sel;
    logic             vld;
    logic [3:0]       ordy;
    logic             exp_irdy;   // before the edge
    logic [3:0]       exp_ov;     // after the edge
    logic [2:0]       exp_occ;
    logic [3:0][31:0] exp_out;
  } vec_t;

  vec_t vt[9];

  // Behavioural model: each channel is a one-word box.
  logic        m_full[4];
  logic [31:0] m_data[4];
  logic [31:0] q[4][$];

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin m_full[i] = 1'b0; m_data[i] = '0; end
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    drive('0, 2'd0, 1'b0, 4'b0000);
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    model_clear();
  endtask

  initial begin
    RST_N = 1'b0;
    drive(32'hFFFF_FFFF, 2'd1, 1'b1, 4'b1111);
    model_clear();

    // Reset held with a valid input pending.
    repeat (2) @(negedge CLK);
    chk("rst_in_ready", In_ready, 0);
    chk("rst_out_valid", Out_valid, 0);
    chk("rst_occ", Occupancy, 0);
    chk("rst_outs", outs, 0);
    RST_N = 1'b1;
    drive('0, 2'd0, 1'b1, 4'b0000);
    #1 chk("rel_in_ready", In_ready, 1);
    In_valid = 1'b0;

    // Routing, fill, drain, same-cycle drain+refill.
    vt[0] = '{32'h1111_1111, 2'd0, 1, 4'b0000, 1, 4'b0001, 3'd1, {32'h0, 32'h0, 32'h0, 32'h1111_1111}};
    vt[1] = '{32'h2222_2222, 2'd1, 1, 4'b0000, 1, 4'b0011, 3'd2, {32'h0, 32'h0, 32'h2222_2222, 32'h1111_1111}};
    vt[2] = '{32'h3333_3333, 2'd2, 1, 4'b0000, 1, 4'b0111, 3'd3, {32'h0, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}};
    vt[3] = '{32'h4444_4444, 2'd3, 1, 4'b0000, 1, 4'b1111, 3'd4, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}};
    vt[4] = '{32'h5555_5555, 2'd2, 1, 4'b0000, 0, 4'b1111, 3'd4, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}};
    vt[5] = '{32'hABAB_ABAB, 2'd1, 1, 4'b0001, 0, 4'b1110, 3'd3, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111}};
    vt[6] = '{32'hDEAD_0000, 2'd0, 1, 4'b0000, 1, 4'b1111, 3'd4, {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'hDEAD_0000}};
    vt[7] = '{32'hBEEF_0000, 2'd2, 1, 4'b0100, 1, 4'b1111, 3'd4, {32'h4444_4444, 32'hBEEF_0000, 32'h2222_2222, 32'hDEAD_0000}};
    vt[8] = '{32'h0000_0000, 2'd0, 0, 4'b1111, 1, 4'b0000, 3'd0, {32'h4444_4444, 32'hBEEF_0000, 32'h2222_2222, 32'hDEAD_0000}};

    for (int i = 0; i < 9; i++) begin
      @(negedge CLK);
      drive(vt[i].din, vt[i].sel, vt[i].vld, vt[i].ordy);
      #1 chk($sformatf("vec%0d_in_ready", i), In_ready, vt[i].exp_irdy);
      @(posedge CLK); #1;
      chk($sformatf("vec%0d_out_valid", i), Out_valid, vt[i].exp_ov);
      chk($sformatf("vec%0d_occ", i), Occupancy, vt[i].exp_occ);
      chk($sformatf("vec%0d_outs", i), outs, vt[i].exp_out);
    end

    // Channel 0 stalled must not block channel 1.
    @(negedge CLK); drive(32'hA0A0_A0A0, 2'd0, 1'b1, 4'b0000);
    @(negedge CLK); drive(32'hABCD_0001, 2'd1, 1'b1, 4'b0000);
    #1 chk("indep_in_ready", In_ready, 1);
    @(negedge CLK); In_valid = 1'b0;
    chk("indep_out1", Out1, 32'hA0A0_A0A0);
    chk("indep_out2", Out2, 32'hABCD_0001);
    chk("indep_valid", Out_valid, 4'b0011);

    // Stalled on full channel 0, then Sel moves to an empty channel.
    drive(32'h7777_0000, 2'd0, 1'b1, 4'b0000);
    #1 chk("selchg_stall", In_ready, 0);
    @(negedge CLK);
    chk("selchg_no_write", Out1, 32'hA0A0_A0A0);
    Sel = 2'd3;
    #1 chk("selchg_ready", In_ready, 1);
    @(negedge CLK); In_valid = 1'b0;
    chk("selchg_out4", Out4, 32'h7777_0000);
    chk("selchg_occ", Occupancy, 3);

    // Asynchronous reset between edges with three channels full.
    #2 RST_N = 1'b0;
    #1;
    chk("arst_valid", Out_valid, 0);
    chk("arst_occ", Occupancy, 0);
    chk("arst_outs", outs, 0);
    chk("arst_in_ready", In_ready, 0);
    @(negedge CLK); RST_N = 1'b1;
    drive(32'hC0DE_0002, 2'd2, 1'b1, 4'b0000);
    @(negedge CLK); In_valid = 1'b0;
    chk("arst_after_valid", Out_valid, 4'b0100);
    chk("arst_after_out3", Out3, 32'hC0DE_0002);
    chk("arst_after_occ", Occupancy, 1);

    // Randomized run against the slot model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      logic exp_rdy, acc;
      logic [2:0] cnt;
      @(negedge CLK);
      drive($urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 4'($urandom));
      #1;
      exp_rdy = !m_full[Sel] || Out_ready[Sel];
      chk("rand_in_ready", In_ready, exp_rdy);
      cnt = 0;
      for (int i = 0; i < 4; i++) begin
        chk("rand_valid", Out_valid[i], m_full[i]);
        chk("rand_data", outs[i], m_data[i]);
        cnt += 3'(m_full[i]);
      end
      chk("rand_occ", Occupancy, cnt);
      acc = In_valid && exp_rdy;
      for (int i = 0; i < 4; i++) begin
        if (acc && Sel == 2'(i)) begin m_full[i] = 1'b1; m_data[i] = In; end
        else if (m_full[i] && Out_ready[i]) m_full[i] = 1'b0;
      end
    end

    // Streaming with every consumer ready: no stalls, in order per channel.
    do_reset();
    for (int c = 0; c < 102; c++) begin
      @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
        if (Out_valid[i]) begin
          if (q[i].size() == 0) chk("stream_extra", outs[i], 0);
          else chk("stream_data", outs[i], q[i].pop_front());
        end
      end
      if (c < 100) begin
        drive($urandom, 2'($urandom_range(0, 3)), 1'b1, 4'b1111);
        #1 chk("stream_no_stall", In_ready, 1);
        q[Sel].push_back(In);
      end else begin
        In_valid = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++) chk("stream_left", q[i].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
